// File: rtl/adder_test_pkg.sv
// Shared types and constants for the adder BIST blocks.
package adder_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned      ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/adder_golden_model.sv
// Reference adder: full-precision a+b, carry in the MSB.
module adder_golden_model #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);

    assign sum_o = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive operand sequencer and response checker for a WIDTH-bit adder.
// Holds each {a,b} for SETTLE cycles, checks on the following cycle.
module adder_bist_checker
    import adder_test_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_carry,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH-1:0]   fail_vec
);

    localparam int unsigned     VW          = 2 * WIDTH;
    localparam int unsigned     SW          = 4;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [VW-1:0]   VEC_LAST    = '1;

    state_e              state_q, state_d;
    logic [VW-1:0]       vec_q, vec_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                fail_valid_q, fail_valid_d;
    logic [VW-1:0]       fail_vec_q, fail_vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic [WIDTH:0]      golden;
    logic                mismatch;

    adder_golden_model #(.WIDTH(WIDTH)) u_golden (
        .a_i   (vec_q[VW-1:WIDTH]),
        .b_i   (vec_q[WIDTH-1:0]),
        .sum_o (golden)
    );

    assign mismatch = (golden != {dut_carry, dut_sum});

    // Next-state, counters and result bookkeeping
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = DRIVE;
                    vec_d        = '0;
                    settle_d     = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + VW'(1);
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the state being entered so they register in step
        busy_d = (state_d == DRIVE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_a      = vec_q[VW-1:WIDTH];
    assign dut_b      = vec_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench: three checker instances (W1/S1, W4/S3, W2/S2) against behavioural adders.
module tb_adder_bist_checker;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // W1 S1 instance with optional stuck-at-0 carry
    logic       start1, carry_fault1;
    logic [0:0] a1, b1, sum1;
    logic       carry1, busy1, done1, pass1, fv1;
    logic [15:0] err1;
    logic [1:0]  fvec1;

    // W4 S3 instance with sum bit 0 inverted
    logic        start4;
    logic [3:0]  a4, b4, sum4;
    logic [4:0]  t4;
    logic        carry4, busy4, done4, pass4, fv4;
    logic [15:0] err4;
    logic [7:0]  fvec4;

    // W2 S2 instance with a correct adder
    logic        start2;
    logic [1:0]  a2, b2, sum2;
    logic        carry2, busy2, done2, pass2, fv2;
    logic [15:0] err2;
    logic [3:0]  fvec2;

    adder_bist_checker #(.WIDTH(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_sum(sum1), .dut_carry(carry1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    adder_bist_checker #(.WIDTH(4), .SETTLE(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .dut_a(a4), .dut_b(b4), .dut_sum(sum4), .dut_carry(carry4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_valid(fv4), .fail_vec(fvec4)
    );

    adder_bist_checker #(.WIDTH(2), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_sum(sum2), .dut_carry(carry2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_vec(fvec2)
    );

    always_comb begin
        sum1   = a1 ^ b1;
        carry1 = carry_fault1 ? 1'b0 : (a1[0] & b1[0]);
        t4     = 5'(a4) + 5'(b4);
        sum4   = t4[3:0] ^ 4'h1;
        carry4 = t4[4];
        {carry2, sum2} = 3'(a2) + 3'(b2);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        carry_fault1 = 1'b0;

        #12;
        check("rst_ab",   {30'd0, a1, b1}, 32'd0);
        check("rst_flag", {29'd0, busy1, done1, pass1}, 32'd0);
        check("rst_err",  {16'd0, err1}, 32'd0);
        check("rst_fail", {29'd0, fv1, fvec1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Run 1: W1 correct half adder; each vector held two cycles, done at E0+9
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("w1_vec_c%0d", k), {30'd0, a1, b1}, 32'((k - 1) / 2));
            check($sformatf("w1_busy_c%0d", k), {30'd0, busy1, done1}, 32'd2);
            step();
        end
        check("w1_done",  {30'd0, busy1, done1}, 32'd1);
        check("w1_pass",  {31'd0, pass1}, 32'd1);
        check("w1_err",   {16'd0, err1}, 32'd0);
        check("w1_fv",    {31'd0, fv1}, 32'd0);

        // Run 2: restart from DONE with carry stuck at 0; a start pulse mid-run is ignored
        carry_fault1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("rs_vec0",  {30'd0, a1, b1}, 32'd0);
        check("rs_flags", {30'd0, busy1, done1}, 32'd2);
        check("rs_clear", {15'd0, err1, fv1}, 32'd0);
        step();
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("busy_start_vec", {30'd0, a1, b1}, 32'd1);
        for (int k = 4; k < 8; k++) step();
        check("sa0_not_done_c8", {31'd0, done1}, 32'd0);
        step();
        check("sa0_done_c9", {31'd0, done1}, 32'd1);
        check("sa0_pass",    {31'd0, pass1}, 32'd0);
        check("sa0_err",     {16'd0, err1}, 32'd1);
        check("sa0_fvec",    {29'd0, fv1, fvec1}, 32'h7);

        // Run 3: W4 S3 with sum bit 0 inverted; every vector fails
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 1;
        check("w4_vec0", {24'd0, a4, b4}, 32'd0);
        while (!done4 && cyc < 2000) begin
            step();
            cyc++;
        end
        check("w4_done_cycle", 32'(cyc), 32'd1025);
        check("w4_err",        {16'd0, err4}, 32'd256);
        check("w4_fail",       {23'd0, fv4, fvec4}, 32'h100);
        check("w4_pass",       {30'd0, busy4, pass4}, 32'd0);

        // Run 4: W2 S2, reset while checking vector 5, then a clean rerun
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 1; k < 18; k++) step();
        check("w2_vec5", {28'd0, a2, b2}, 32'd5);
        check("w2_busy", {31'd0, busy2}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ab",   {28'd0, a2, b2}, 32'd0);
        check("mid_rst_flag", {29'd0, busy2, done2, pass2}, 32'd0);
        check("mid_rst_res",  {11'd0, err2, fv2, fvec2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_rst", {30'd0, busy2, done2}, 32'd0);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        cyc = 1;
        check("rerun_vec0", {28'd0, a2, b2}, 32'd0);
        check("rerun_busy", {31'd0, busy2}, 32'd1);
        while (!done2 && cyc < 200) begin
            step();
            cyc++;
        end
        check("w2_done_cycle", 32'(cyc), 32'd49);
        check("w2_pass",       {31'd0, pass2}, 32'd1);
        check("w2_res",        {11'd0, err2, fv2, fvec2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
